// File: rtl/vpu_pkg.sv
// Shared register map, CTRL bit positions and DMA FSM states for the video line-fetch DMA.
package vpu_pkg;

  localparam logic [2:0] REG_ADDR_H = 3'd0;
  localparam logic [2:0] REG_ADDR_L = 3'd1;
  localparam logic [2:0] REG_STEP   = 3'd2;
  localparam logic [2:0] REG_LEN    = 3'd3;
  localparam logic [2:0] REG_CPTR   = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;

  localparam int unsigned CTRL_GO   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IEN  = 2;
  localparam int unsigned CTRL_CLR  = 7;

  typedef enum logic [2:0] {IDLE, REQ, RD, CAP, REL} dma_state_e;

endpackage

// File: rtl/vpu_dma_engine_if.sv
// CPU register bus, memory hold/hlda bus, line trigger and cache read port.
// slave = DMA engine side, master = system side.
interface vpu_dma_engine_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 16,
  parameter int unsigned CW  = 6
);
  logic [2+$clog2(NCH):0] AD;
  logic [7:0]             DI;
  logic [7:0]             DO;
  logic                   rw;
  logic                   cs;
  logic                   irq;
  logic                   hold;
  logic                   hlda;
  logic [AW-1:0]          VADDR;
  logic [7:0]             VDATA;
  logic                   vramcs;
  logic                   line_start;
  logic [CW-1:0]          rd_addr;
  logic [7:0]             rd_data;

  modport slave  (input  AD, DI, rw, cs, hlda, VDATA, line_start, rd_addr,
                  output DO, irq, hold, VADDR, vramcs, rd_data);
  modport master (output AD, DI, rw, cs, hlda, VDATA, line_start, rd_addr,
                  input  DO, irq, hold, VADDR, vramcs, rd_data);
endinterface

// File: rtl/vpu_line_cache.sv
// Line cache: 1 write / 1 read synchronous RAM, DEPTH x 8, read-before-write on the same index.
module vpu_line_cache #(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AWC   = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [AWC-1:0] waddr_i,
  input  logic [7:0]     wdata_i,
  input  logic [AWC-1:0] raddr_i,
  output logic [7:0]     rdata_o
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/vpu_dma_engine.sv
// Multi-channel line-fetch DMA: per-channel register files, lowest-index arbiter,
// burst FSM on the hold/hlda bus and the shared line cache.
module vpu_dma_engine
  import vpu_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned AW          = 16,
  parameter int unsigned CACHE_DEPTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  vpu_dma_engine_if.slave    bus
);
  localparam int unsigned CW  = $clog2(CACHE_DEPTH);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  dma_state_e     state_q, state_d;
  logic           hold_q, hold_d;
  logic [CHW-1:0] cur_q, arb_sel, ch_sel;
  logic [7:0]     cnt_q, do_q;
  logic [AW-1:0]  vaddr_q, vaddr;
  logic           latch, cap, rel, vramcs, any_pend;
  logic [2:0]     reg_sel;

  logic [AW-1:0]  addr_w  [NCH];
  logic [CW-1:0]  cptr_w  [NCH];
  logic [7:0]     len_w   [NCH];
  logic [7:0]     rdata_w [NCH];
  logic [NCH-1:0] pend_w, done_w, ien_w;

  assign reg_sel = bus.AD[2:0];
  assign ch_sel  = CHW'(bus.AD >> 3);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [AW-1:0] addr_q;
    logic [7:0]    step_q, len_q, rdata;
    logic [CW-1:0] cptr_q;
    logic          pend_q, busy_q, done_q, auto_q, ien_q;
    logic          wr, mine, go, clr, trig;
    logic [15:0]   addr16;

    always_comb begin
      wr     = bus.cs & ~bus.rw & (ch_sel == CHW'(g));
      mine   = (cur_q == CHW'(g));
      go     = wr & (reg_sel == REG_CTRL) & bus.DI[CTRL_GO];
      clr    = wr & (reg_sel == REG_CTRL) & bus.DI[CTRL_CLR];
      trig   = (go | (auto_q & bus.line_start)) & (len_q != '0) & ~busy_q;
      addr16 = 16'(addr_q);
      case (reg_sel)
        REG_ADDR_H: rdata = addr16[15:8];
        REG_ADDR_L: rdata = addr16[7:0];
        REG_STEP:   rdata = step_q;
        REG_LEN:    rdata = len_q;
        REG_CPTR:   rdata = 8'(cptr_q);
        REG_CTRL:   rdata = {done_q, 4'b0000, ien_q, auto_q, busy_q};
        default:    rdata = '0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        addr_q <= '0;
        step_q <= 8'd1;
        len_q  <= '0;
        cptr_q <= '0;
        pend_q <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
        auto_q <= 1'b0;
        ien_q  <= 1'b0;
      end else begin
        if (cap && mine) begin
          addr_q <= addr_q + AW'(step_q);
          cptr_q <= cptr_q + CW'(1);
        end else if (wr && !busy_q) begin
          case (reg_sel)
            REG_ADDR_H: addr_q <= AW'({bus.DI, addr16[7:0]});
            REG_ADDR_L: addr_q <= AW'({addr16[15:8], bus.DI});
            REG_STEP:   step_q <= bus.DI;
            REG_LEN:    len_q  <= bus.DI;
            REG_CPTR:   cptr_q <= CW'(bus.DI);
            default:    ;
          endcase
        end
        if (wr && reg_sel == REG_CTRL) begin
          auto_q <= bus.DI[CTRL_AUTO];
          ien_q  <= bus.DI[CTRL_IEN];
        end
        if (latch && arb_sel == CHW'(g)) begin
          pend_q <= 1'b0;
          busy_q <= 1'b1;
        end else if (trig) begin
          pend_q <= 1'b1;
        end
        // DONE set beats a racing CPU clear
        if (rel && mine) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else if (clr) begin
          done_q <= 1'b0;
        end
      end
    end

    assign addr_w[g]  = addr_q;
    assign cptr_w[g]  = cptr_q;
    assign len_w[g]   = len_q;
    assign rdata_w[g] = rdata;
    assign pend_w[g]  = pend_q;
    assign done_w[g]  = done_q;
    assign ien_w[g]   = ien_q;
  end

  always_comb begin
    any_pend = 1'b0;
    arb_sel  = '0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (pend_w[i-1]) begin
        any_pend = 1'b1;
        arb_sel  = CHW'(i - 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    latch   = 1'b0;
    cap     = 1'b0;
    rel     = 1'b0;
    vramcs  = 1'b0;
    case (state_q)
      IDLE: if (any_pend) begin
        latch   = 1'b1;
        hold_d  = 1'b1;
        state_d = REQ;
      end
      REQ: if (bus.hlda) state_d = RD;
      RD: if (bus.hlda) begin
        vramcs  = 1'b1;
        state_d = CAP;
      end
      CAP: begin
        cap     = 1'b1;
        state_d = (cnt_q == len_w[cur_q] - 8'd1) ? REL : RD;
      end
      REL: begin
        rel     = 1'b1;
        // keep the bus if another channel is already waiting
        hold_d  = |pend_w;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign vaddr = (state_q == RD) ? addr_w[cur_q] : vaddr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      cur_q   <= '0;
      cnt_q   <= '0;
      vaddr_q <= '0;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vaddr_q <= vaddr;
      if (latch) cur_q <= arb_sel;
      if (latch)    cnt_q <= '0;
      else if (cap) cnt_q <= cnt_q + 8'd1;
      if (bus.cs && bus.rw) do_q <= (32'(ch_sel) < NCH) ? rdata_w[ch_sel] : '0;
    end
  end

  vpu_line_cache #(.DEPTH(CACHE_DEPTH)) u_cache (
    .clk_i   (clk),
    .we_i    (cap),
    .waddr_i (cptr_w[cur_q]),
    .wdata_i (bus.VDATA),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.DO     = do_q;
  assign bus.hold   = hold_q;
  assign bus.vramcs = vramcs;
  assign bus.VADDR  = vaddr;
  assign bus.irq    = |(done_w & ien_w);

endmodule

// File: tb/tb_vpu_dma_engine.sv
module tb_vpu_dma_engine;
  import vpu_pkg::*;

  localparam int unsigned NCH = 2, AW = 16, DEPTH = 64, CW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpu_dma_engine_if #(.NCH(NCH), .AW(AW), .CW(CW)) bus ();

  vpu_dma_engine #(.NCH(NCH), .AW(AW), .CACHE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {logic [5:0] idx; logic [7:0] data;} cache_exp_t;

  int passed = 0, total = 0;
  logic [15:0] exp_addr_q [$];
  cache_exp_t  exp_cache_q [$];
  logic        mreq = 1'b0;
  logic [15:0] maddr = '0;
  int hold_cnt = 0, hold_len = 0, hold_runs = 0;

  function automatic logic [7:0] memf(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // read-address scoreboard and hold-window measurement
  initial forever begin
    @(negedge clk);
    mreq  = bus.vramcs;
    maddr = bus.VADDR;
    if (bus.vramcs === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        total++;
        $error("FAIL unexpected_read: observed VADDR %0h expected no read", bus.VADDR);
      end else begin
        check("vaddr", 32'(bus.VADDR), 32'(exp_addr_q.pop_front()));
      end
    end
    if (bus.hold === 1'b1) hold_cnt++;
    else if (hold_cnt != 0) begin
      hold_len  = hold_cnt;
      hold_runs++;
      hold_cnt  = 0;
    end
  end

  // external memory: data one clock after the strobe
  initial forever begin
    @(posedge clk);
    #1;
    if (mreq) bus.VDATA = memf(maddr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cpu_wr(int ch, logic [2:0] r, logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = {ch[0], r}; bus.DI = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rw = 1'b1;
  endtask

  task automatic rd_check(string tag, int ch, logic [2:0] r, logic [7:0] exp);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = {ch[0], r};
    @(posedge clk); #1;
    bus.cs = 1'b0;
    check(tag, 32'(bus.DO), 32'(exp));
  endtask

  task automatic setup(int ch, logic [15:0] a, logic [7:0] step, logic [7:0] len, logic [7:0] cp);
    cpu_wr(ch, REG_ADDR_H, a[15:8]);
    cpu_wr(ch, REG_ADDR_L, a[7:0]);
    cpu_wr(ch, REG_STEP, step);
    cpu_wr(ch, REG_LEN, len);
    cpu_wr(ch, REG_CPTR, cp);
  endtask

  task automatic push_burst(logic [15:0] a, logic [7:0] step, logic [7:0] len, logic [5:0] cp);
    for (int unsigned i = 0; i < 32'(len); i++) begin
      exp_addr_q.push_back(a);
      exp_cache_q.push_back('{idx: cp, data: memf(a)});
      a  = a + 16'(step);
      cp = cp + 6'd1;
    end
  endtask

  task automatic wait_runs(string tag, int target, int budget);
    for (int i = 0; i < budget && hold_runs < target; i++) @(posedge clk);
    #1;
    check(tag, 32'(hold_runs), 32'(target));
  endtask

  task automatic wait_read(string tag);
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.vramcs === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_cache(string tag);
    cache_exp_t e;
    while (exp_cache_q.size() > 0) begin
      e = exp_cache_q.pop_front();
      bus.rd_addr = e.idx;
      @(posedge clk); #1;
      check(tag, 32'(bus.rd_data), 32'(e.data));
    end
  endtask

  task automatic pulse_line();
    bus.line_start = 1'b1;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
  endtask

  initial begin
    int runs0;
    bus.cs = 1'b0; bus.rw = 1'b1; bus.AD = '0; bus.DI = '0; bus.hlda = 1'b1;
    bus.VDATA = '0; bus.line_start = 1'b0; bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    check("rst_hold", 32'(bus.hold), 32'd0);
    check("rst_vramcs", 32'(bus.vramcs), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_do", 32'(bus.DO), 32'd0);
    rd_check("rst_step", 0, REG_STEP, 8'd1);
    rd_check("rst_addr_l", 1, REG_ADDR_L, 8'd0);
    rd_check("rst_ctrl", 0, REG_CTRL, 8'd0);

    // basic burst
    setup(0, 16'h1000, 8'd1, 8'd4, 8'd0);
    push_burst(16'h1000, 8'd1, 8'd4, 6'd0);
    runs0 = hold_runs;
    cpu_wr(0, REG_CTRL, 8'h01);
    wait_runs("t1_done", runs0 + 1, 100);
    check("t1_burst_clks", 32'(hold_len), 32'd10);
    rd_check("t1_addr_h", 0, REG_ADDR_H, 8'h10);
    rd_check("t1_addr_l", 0, REG_ADDR_L, 8'h04);
    rd_check("t1_cptr", 0, REG_CPTR, 8'h04);
    rd_check("t1_ctrl", 0, REG_CTRL, 8'h80);
    check("t1_reads_all", 32'(exp_addr_q.size()), 32'd0);
    check_cache("t1_cache");

    // arbitration: both channels triggered in the same clock
    setup(0, 16'h2000, 8'd1, 8'd4, 8'd8);
    setup(1, 16'h3000, 8'd2, 8'd3, 8'd16);
    cpu_wr(0, REG_CTRL, 8'h82);
    cpu_wr(1, REG_CTRL, 8'h02);
    push_burst(16'h2000, 8'd1, 8'd4, 6'd8);
    push_burst(16'h3000, 8'd2, 8'd3, 6'd16);
    runs0 = hold_runs;
    pulse_line();
    wait_runs("t2_done", runs0 + 1, 200);
    check("t2_hold_continuous", 32'(hold_len), 32'd19);
    rd_check("t2_ctrl0", 0, REG_CTRL, 8'h82);
    rd_check("t2_ctrl1", 1, REG_CTRL, 8'h82);
    check("t2_reads_all", 32'(exp_addr_q.size()), 32'd0);
    check_cache("t2_cache");
    cpu_wr(0, REG_CTRL, 8'h80);
    cpu_wr(1, REG_CTRL, 8'h80);

    // address wrap, stride, cache pointer wrap
    setup(0, 16'hFFFE, 8'd3, 8'd3, 8'd62);
    push_burst(16'hFFFE, 8'd3, 8'd3, 6'd62);
    runs0 = hold_runs;
    cpu_wr(0, REG_CTRL, 8'h01);
    wait_runs("t3_done", runs0 + 1, 100);
    check("t3_burst_clks", 32'(hold_len), 32'd8);
    rd_check("t3_addr_h", 0, REG_ADDR_H, 8'h00);
    rd_check("t3_addr_l", 0, REG_ADDR_L, 8'h07);
    rd_check("t3_cptr", 0, REG_CPTR, 8'h01);
    check_cache("t3_cache");

    // hlda withdrawn for 5 clocks in the middle of a burst
    setup(1, 16'h4000, 8'd1, 8'd4, 8'd32);
    push_burst(16'h4000, 8'd1, 8'd4, 6'd32);
    runs0 = hold_runs;
    cpu_wr(1, REG_CTRL, 8'h01);
    wait_read("t4_first_read");
    @(posedge clk);
    @(posedge clk);
    #1 bus.hlda = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_pause_vramcs", 32'(bus.vramcs), 32'd0);
      @(posedge clk);
    end
    #1 bus.hlda = 1'b1;
    wait_runs("t4_done", runs0 + 1, 100);
    check("t4_burst_clks", 32'(hold_len), 32'd15);
    check("t4_reads_all", 32'(exp_addr_q.size()), 32'd0);
    check_cache("t4_cache");

    // AUTO trigger, IRQ and a DONE clear racing DONE set
    setup(0, 16'h5000, 8'd1, 8'd2, 8'd40);
    cpu_wr(0, REG_CTRL, 8'h86);
    check("t5_irq_cleared", 32'(bus.irq), 32'd0);
    push_burst(16'h5000, 8'd1, 8'd2, 6'd40);
    runs0 = hold_runs;
    pulse_line();
    wait_runs("t5_done1", runs0 + 1, 100);
    check("t5_burst_clks", 32'(hold_len), 32'd6);
    check("t5_irq_set", 32'(bus.irq), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    push_burst(16'h5002, 8'd1, 8'd2, 6'd42);
    pulse_line();
    repeat (5) @(posedge clk);
    #1;
    cpu_wr(0, REG_CTRL, 8'h86);
    wait_runs("t5_done2", runs0 + 2, 100);
    rd_check("t5_race_ctrl", 0, REG_CTRL, 8'h86);
    check("t5_irq_held", 32'(bus.irq), 32'd1);
    rd_check("t5_addr_h", 0, REG_ADDR_H, 8'h50);
    rd_check("t5_addr_l", 0, REG_ADDR_L, 8'h04);
    cpu_wr(0, REG_CTRL, 8'h80);
    check("t5_irq_off", 32'(bus.irq), 32'd0);
    check_cache("t5_cache");

    // GO and register writes to a busy channel are ignored
    setup(0, 16'h6000, 8'd1, 8'd2, 8'd0);
    push_burst(16'h6000, 8'd1, 8'd2, 6'd0);
    runs0 = hold_runs;
    cpu_wr(0, REG_CTRL, 8'h01);
    @(posedge clk); #1;
    cpu_wr(0, REG_CTRL, 8'h01);
    cpu_wr(0, REG_LEN, 8'd9);
    wait_runs("t6_done", runs0 + 1, 100);
    repeat (10) @(posedge clk);
    #1;
    check("t6_single_burst", 32'(hold_runs), 32'(runs0 + 1));
    check("t6_hold_low", 32'(bus.hold), 32'd0);
    rd_check("t6_len_kept", 0, REG_LEN, 8'd2);

    // reset in the middle of a burst
    setup(0, 16'h7000, 8'd1, 8'd8, 8'd0);
    push_burst(16'h7000, 8'd1, 8'd8, 6'd0);
    cpu_wr(0, REG_CTRL, 8'h05);
    wait_read("t7_first_read");
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t7_hold", 32'(bus.hold), 32'd0);
    check("t7_vramcs", 32'(bus.vramcs), 32'd0);
    exp_addr_q.delete();
    exp_cache_q.delete();
    rst_n = 1'b1;
    rd_check("t7_step", 0, REG_STEP, 8'd1);
    rd_check("t7_addr_h", 0, REG_ADDR_H, 8'd0);
    rd_check("t7_addr_l", 0, REG_ADDR_L, 8'd0);
    rd_check("t7_len", 0, REG_LEN, 8'd0);
    rd_check("t7_cptr", 0, REG_CPTR, 8'd0);
    rd_check("t7_ctrl", 0, REG_CTRL, 8'd0);
    check("t7_irq", 32'(bus.irq), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
